// File: rtl/fpu_sched.sv
// fpu_sched: shares one combinational fpu datapath between two requesters.
// One operation is in flight at a time. Its operands and opcode are held on
// the fpu lines for a per-opcode latency. The registered result then returns
// to the issuing requester over a valid/ready response channel.
// Optional feature: define FPU_SCHED_RR_EN for round-robin arbitration.
// Without it, requester 0 has fixed priority.
module fpu_sched #(
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8,
  parameter int CVT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [63:0] req0_in1,
  input  logic [63:0] req0_in2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [63:0] req1_in1,
  input  logic [63:0] req1_in2,
  output logic [63:0] fpu_in1,
  output logic [63:0] fpu_in2,
  output logic [2:0]  fpu_op,
  input  logic [63:0] fpu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_data,
  output logic        rsp_illegal,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        grant;
  logic        accept;
  logic [2:0]  sel_op;
  logic [63:0] sel_in1;
  logic [63:0] sel_in2;

`ifdef FPU_SCHED_RR_EN
  logic        last_grant;
`endif

  // Number of EXEC cycles minus one, so the counter reaching zero marks the last cycle
  function automatic logic [7:0] lat_m1(input logic [2:0] op);
    case (op)
      3'b000, 3'b001: lat_m1 = 8'(ADD_LAT - 1);
      3'b010:         lat_m1 = 8'(MUL_LAT - 1);
      3'b011:         lat_m1 = 8'(DIV_LAT - 1);
      3'b101, 3'b110: lat_m1 = 8'(CVT_LAT - 1);
      default:        lat_m1 = 8'd0;
    endcase
  endfunction

  // Opcodes with no fpu meaning get a one-cycle slot and a zeroed result
  function automatic logic is_illegal(input logic [2:0] op);
    is_illegal = (op == 3'b100) || (op == 3'b111);
  endfunction

  // Choose a requester. Only the valid one wins; a tie goes to the arbitration policy
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef FPU_SCHED_RR_EN
      grant = ~last_grant;
`else
      grant = 1'b0;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && !rst && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && !rst && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign sel_op  = grant ? req1_op  : req0_op;
  assign sel_in1 = grant ? req1_in1 : req0_in1;
  assign sel_in2 = grant ? req1_in2 : req0_in2;

  // Scheduler FSM: accept, hold the fpu lines for the op latency, then present the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      fpu_in1     <= 64'd0;
      fpu_in2     <= 64'd0;
      fpu_op      <= 3'd0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= 64'd0;
      rsp_illegal <= 1'b0;
      busy        <= 1'b0;
`ifdef FPU_SCHED_RR_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            fpu_op  <= sel_op;
            fpu_in1 <= sel_in1;
            fpu_in2 <= sel_in2;
            rsp_id  <= grant;
            cnt     <= lat_m1(sel_op);
            busy    <= 1'b1;
            state   <= EXEC;
`ifdef FPU_SCHED_RR_EN
            last_grant <= grant;
`endif
          end
        end
        EXEC: begin
          if (cnt == 8'd0) begin
            rsp_data    <= is_illegal(fpu_op) ? 64'd0 : fpu_out;
            rsp_illegal <= is_illegal(fpu_op);
            rsp_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: directed and randomized bench for fpu_sched.
// A behavioural fpu stub drives fpu_out. The expected grant, latency and
// result of every operation come from a transaction-level model kept here.
module tb_fpu_sched;

  localparam int ADD_LAT = 1;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;
  localparam int CVT_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [2:0]  req0_op = 3'd0;
  logic [63:0] req0_in1 = 64'd0;
  logic [63:0] req0_in2 = 64'd0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [2:0]  req1_op = 3'd0;
  logic [63:0] req1_in1 = 64'd0;
  logic [63:0] req1_in2 = 64'd0;
  logic [63:0] fpu_in1;
  logic [63:0] fpu_in2;
  logic [2:0]  fpu_op;
  logic [63:0] fpu_out;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [63:0] rsp_data;
  logic        rsp_illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit exp_last = 1'b1;
  int lat_tbl [0:7];

  fpu_sched #(
    .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CVT_LAT(CVT_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_op(fpu_op), .fpu_out(fpu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared fpu; illegal opcodes return garbage on purpose
  function automatic logic [63:0] fpu_fn(input logic [2:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    real x;
    real y;
    x = $bitstoreal(a);
    y = $bitstoreal(b);
    case (op)
      3'd0:    return $realtobits(x + y);
      3'd1:    return $realtobits(x - y);
      3'd2:    return $realtobits(x * y);
      3'd3:    return $realtobits(x / y);
      3'd5:    return a ^ b;
      3'd6:    return ~a;
      default: return 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  endfunction

  assign fpu_out = fpu_fn(fpu_op, fpu_in1, fpu_in2);

  function automatic logic [63:0] rnd_real();
    return $realtobits(real'($urandom_range(1, 100)));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction: offer requests, check the grant, follow it through to the response.
  // Called at a falling edge while the scheduler is idle; returns at a falling edge in IDLE.
  task automatic applyStimulus(input bit v0, input bit v1,
                               input logic [2:0] o0, input logic [63:0] a0, input logic [63:0] b0,
                               input logic [2:0] o1, input logic [63:0] a1, input logic [63:0] b1,
                               input int hold, input bit keep);
    bit          g;
    logic [2:0]  eo;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] edata;
    bit          eill;
    int          n;
    req0_valid = v0; req0_op = o0; req0_in1 = a0; req0_in2 = b0;
    req1_valid = v1; req1_op = o1; req1_in1 = a1; req1_in2 = b1;
    rsp_ready  = (hold == 0);
    #1;
`ifdef FPU_SCHED_RR_EN
    g = (v0 && v1) ? !exp_last : v1;
`else
    g = (v0 && v1) ? 1'b0 : v1;
`endif
    checkOutput("req0_ready_grant", req0_ready, v0 && !g);
    checkOutput("req1_ready_grant", req1_ready, v1 && g);
    exp_last = g;
    eo = g ? o1 : o0;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    eill  = (eo == 3'd4) || (eo == 3'd7);
    edata = eill ? 64'd0 : fpu_fn(eo, ea, eb);
    @(negedge clk);
    if (!keep) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    #1;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 300) begin
      checkOutput("exec_busy", busy, 1'b1);
      checkOutput("exec_ready0", req0_ready, 1'b0);
      checkOutput("exec_ready1", req1_ready, 1'b0);
      checkOutput("exec_fpu_op", fpu_op, eo);
      @(negedge clk);
      n++;
    end
    checkOutput("rsp_latency", n, lat_tbl[eo] + 1);
    checkOutput("rsp_data", rsp_data, edata);
    checkOutput("rsp_id", rsp_id, g);
    checkOutput("rsp_illegal", rsp_illegal, eill);
    checkOutput("fpu_in1_hold", fpu_in1, ea);
    checkOutput("fpu_in2_hold", fpu_in2, eb);
    checkOutput("done_busy", busy, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", rsp_valid, 1'b1);
      checkOutput("bp_data", rsp_data, edata);
      checkOutput("bp_id", rsp_id, g);
      checkOutput("bp_ready0", req0_ready, 1'b0);
      checkOutput("bp_ready1", req1_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_rsp_valid", rsp_valid, 1'b0);
  endtask

  initial begin
    lat_tbl = '{ADD_LAT, ADD_LAT, MUL_LAT, DIV_LAT, 1, CVT_LAT, CVT_LAT, 1};

    // Reset values
    #1 rst = 1'b1;
    req0_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready0", req0_ready, 1'b0);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_rsp_id", rsp_id, 1'b0);
    checkOutput("rst_rsp_data", rsp_data, 64'd0);
    checkOutput("rst_rsp_illegal", rsp_illegal, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_fpu_in1", fpu_in1, 64'd0);
    checkOutput("rst_fpu_in2", fpu_in2, 64'd0);
    checkOutput("rst_fpu_op", fpu_op, 3'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed: add on req0, div on req1
    applyStimulus(1, 0, 3'd0, 64'h3FF0000000000000, 64'h4000000000000000,
                  3'd0, 64'd0, 64'd0, 0, 0);
    checkOutput("add_value", rsp_data, 64'h4008000000000000);
    applyStimulus(0, 1, 3'd0, 64'd0, 64'd0,
                  3'd3, 64'h4018000000000000, 64'h4000000000000000, 0, 0);
    checkOutput("div_value", rsp_data, 64'h4008000000000000);

    // Contention: both requesters keep valid asserted
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 3'd0, rnd_real(), rnd_real(), 3'd0, rnd_real(), rnd_real(), 0, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure for five cycles
    applyStimulus(1, 0, 3'd2, rnd_real(), rnd_real(), 3'd0, 64'd0, 64'd0, 5, 0);

    // Illegal opcodes
    applyStimulus(1, 0, 3'd7, rnd_real(), rnd_real(), 3'd0, 64'd0, 64'd0, 0, 0);
    applyStimulus(0, 1, 3'd0, 64'd0, 64'd0, 3'd4, rnd_real(), rnd_real(), 0, 0);

    // Reset during a div: the op is dropped and the next request is taken immediately
    req1_valid = 1'b1; req1_op = 3'd3; req1_in1 = rnd_real(); req1_in2 = rnd_real();
    #1;
    checkOutput("mid_accept", req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_last = 1'b1;
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("mid_rst_fpu_in1", fpu_in1, 64'd0);
    checkOutput("mid_rst_fpu_op", fpu_op, 3'd0);
    checkOutput("mid_rst_ready0", req0_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 0, 3'd1, rnd_real(), rnd_real(), 3'd0, 64'd0, 64'd0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit v0;
      bit v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      applyStimulus(v0, v1, 3'($urandom_range(0, 7)), rnd_real(), rnd_real(),
                    3'($urandom_range(0, 7)), rnd_real(), rnd_real(),
                    int'($urandom_range(0, 3)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
